// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles four little-endian bytes from the
// memory controller into a 32-bit word and presents it to IF_ID with its PC.
module inst_fetch (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  stall_in,
  input  logic        branch_or_not,
  input  logic [31:0] branch_addr,
  input  logic        mem_byte_valid,
  input  logic [7:0]  mem_byte,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        stall_req,
  output logic [31:0] output_pc,
  output logic [31:0] output_instru
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [23:0] byte_buf;

  logic unused_stall;
  assign unused_stall = ^stall_in[5:2];

  // Gated by rst_in so stall control sees no request while the block is held in reset.
  assign stall_req = ~rst_in & (state != HOLD);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      pc            <= 32'd0;
      cnt           <= 2'd0;
      byte_buf      <= 24'd0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'd0;
      output_pc     <= 32'd0;
      output_instru <= 32'd0;
    end else if (rdy_in) begin
      if (branch_or_not) begin
        // Redirect wins over everything, including a byte or word completing this edge.
        state         <= IDLE;
        pc            <= branch_addr;
        cnt           <= 2'd0;
        byte_buf      <= 24'd0;
        mem_req       <= 1'b0;
        mem_addr      <= branch_addr;
        output_pc     <= 32'd0;
        output_instru <= 32'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!stall_in[0]) begin
              state    <= BUSY;
              cnt      <= 2'd0;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end
          end
          BUSY: begin
            if (mem_byte_valid) begin
              if (cnt == 2'd3) begin
                state         <= HOLD;
                output_instru <= {mem_byte, byte_buf};
                output_pc     <= pc;
                pc            <= pc + 32'd4;
                cnt           <= 2'd0;
                mem_req       <= 1'b0;
                mem_addr      <= pc + 32'd4;
              end else begin
                unique case (cnt)
                  2'd0:    byte_buf[7:0]   <= mem_byte;
                  2'd1:    byte_buf[15:8]  <= mem_byte;
                  default: byte_buf[23:16] <= mem_byte;
                endcase
                cnt      <= cnt + 2'd1;
                mem_addr <= pc + {30'd0, cnt} + 32'd1;
              end
            end
          end
          HOLD: begin
            if (!stall_in[1]) begin
              output_pc     <= 32'd0;
              output_instru <= 32'd0;
              cnt           <= 2'd0;
              if (!stall_in[0]) begin
                state    <= BUSY;
                mem_req  <= 1'b1;
                mem_addr <= pc;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table of inputs and expected outputs,
// plus hand-written asynchronous reset sequences.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic        branch_or_not;
  logic [31:0] branch_addr;
  logic        mem_byte_valid;
  logic [7:0]  mem_byte;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        stall_req;
  logic [31:0] output_pc;
  logic [31:0] output_instru;

  inst_fetch dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .stall_in      (stall_in),
    .branch_or_not (branch_or_not),
    .branch_addr   (branch_addr),
    .mem_byte_valid(mem_byte_valid),
    .mem_byte      (mem_byte),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .stall_req     (stall_req),
    .output_pc     (output_pc),
    .output_instru (output_instru)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] baddr;
    logic        mbv;
    logic [7:0]  mb;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic [5:0] stall, input logic br,
                              input logic [31:0] baddr, input logic mbv, input logic [7:0] mb,
                              input logic req, input logic [31:0] addr, input logic sreq,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.rdy = rdy; v.stall = stall; v.br = br; v.baddr = baddr; v.mbv = mbv; v.mb = mb;
    v.req = req; v.addr = addr; v.sreq = sreq; v.pc = pc; v.ins = ins;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " mem_req"},       {31'd0, mem_req},   {31'd0, v.req});
    if (v.req) check({tag, " mem_addr"}, mem_addr, v.addr);
    check({tag, " stall_req"},     {31'd0, stall_req}, {31'd0, v.sreq});
    check({tag, " output_pc"},     output_pc,          v.pc);
    check({tag, " output_instru"}, output_instru,      v.ins);
  endtask

  // Called at a negedge: drive, let one rising edge pass, sample at the next negedge.
  task automatic apply(input string tag, input vec_t v);
    rdy_in         = v.rdy;
    stall_in       = v.stall;
    branch_or_not  = v.br;
    branch_addr    = v.baddr;
    mem_byte_valid = v.mbv;
    mem_byte       = v.mb;
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs(tag, v);
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; stall_in = 6'd0; branch_or_not = 1'b0;
    branch_addr = 32'd0; mem_byte_valid = 1'b0; mem_byte = 8'd0;
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    rdy_in = 1'b0;

    // Reset state, before and after clock edges
    #1;
    check("rst0 mem_req",   {31'd0, mem_req},   32'd0);
    check("rst0 stall_req", {31'd0, stall_req}, 32'd0);
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check_outputs("rst1", mk(1, 0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0));
    check("rst1 mem_addr", mem_addr, 32'd0);

    //               rdy stall br baddr          mbv mb     req addr           sreq pc             ins
    // basic fetch at 0
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h13, 1, 32'h1,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h05, 1, 32'h2,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h10, 1, 32'h3,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h00100513));
    // downstream stall for 3 cycles, stray byte ignored in HOLD
    vecs.push_back(mk(1, 6'h02, 0, 32'h0,        0, 8'h00, 0, 32'h0,        0, 32'h0,        32'h00100513));
    vecs.push_back(mk(1, 6'h02, 0, 32'h0,        1, 8'hAA, 0, 32'h0,        0, 32'h0,        32'h00100513));
    vecs.push_back(mk(1, 6'h02, 0, 32'h0,        0, 8'h00, 0, 32'h0,        0, 32'h0,        32'h00100513));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h4,        1, 32'h0,        32'h0));
    // redirect after two bytes, byte returned on the branch edge discarded
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h11, 1, 32'h5,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h22, 1, 32'h6,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 1, 32'h100,      1, 8'h33, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h100,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h78, 1, 32'h101,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h56, 1, 32'h102,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h34, 1, 32'h103,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h12, 0, 32'h0,        0, 32'h100,      32'h12345678));
    // HOLD with only stall_in[0] -> IDLE, stays there until it drops
    vecs.push_back(mk(1, 6'h01, 0, 32'h0,        0, 8'h00, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h01, 0, 32'h0,        0, 8'h00, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h104,      1, 32'h0,        32'h0));
    // rdy_in gap of 5 cycles between bytes 1 and 2
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hEF, 1, 32'h105,      1, 32'h0,        32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 6'h00, 0, 32'h0,      1, 8'hFF, 1, 32'h105,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hBE, 1, 32'h106,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hAD, 1, 32'h107,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hDE, 0, 32'h0,        0, 32'h104,      32'hDEADBEEF));
    vecs.push_back(mk(0, 6'h00, 0, 32'h0,        0, 8'h00, 0, 32'h0,        0, 32'h104,      32'hDEADBEEF));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h108,      1, 32'h0,        32'h0));
    // branch on the final byte: word dropped, PC becomes target
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h01, 1, 32'h109,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h02, 1, 32'h10A,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h03, 1, 32'h10B,      1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 1, 32'h8,        1, 8'h04, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h8,        1, 32'h0,        32'h0));
    // PC wrap from 0xFFFFFFFC
    vecs.push_back(mk(1, 6'h00, 1, 32'hFFFFFFFC, 0, 8'h00, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'hFFFFFFFC, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hAA, 1, 32'hFFFFFFFD, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hBB, 1, 32'hFFFFFFFE, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hCC, 1, 32'hFFFFFFFF, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'hDD, 0, 32'h0,        0, 32'hFFFFFFFC, 32'hDDCCBBAA));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h0,        1, 32'h0,        32'h0));
    // move away from address 0 so a reset restart is visible
    vecs.push_back(mk(1, 6'h00, 1, 32'h40,       0, 8'h00, 0, 32'h0,        1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        0, 8'h00, 1, 32'h40,       1, 32'h0,        32'h0));
    vecs.push_back(mk(1, 6'h00, 0, 32'h0,        1, 8'h55, 1, 32'h41,       1, 32'h0,        32'h0));

    rst_in = 1'b0;
    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("v%0d", i), vecs[i]);

    // Asynchronous reset pulse between edges, mid-BUSY
    idle_inputs();
    #2 rst_in = 1'b1;
    #1;
    check("arst_busy mem_req",   {31'd0, mem_req},   32'd0);
    check("arst_busy mem_addr",  mem_addr,           32'd0);
    check("arst_busy stall_req", {31'd0, stall_req}, 32'd0);
    check("arst_busy output_pc", output_pc,          32'd0);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs("restart", mk(1, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h0));
    check("restart mem_addr", mem_addr, 32'h0);
    apply("rs1", mk(1, 6'h00, 0, 32'h0, 1, 8'h01, 1, 32'h1, 1, 32'h0, 32'h0));
    apply("rs2", mk(1, 6'h00, 0, 32'h0, 1, 8'h02, 1, 32'h2, 1, 32'h0, 32'h0));
    apply("rs3", mk(1, 6'h00, 0, 32'h0, 1, 8'h03, 1, 32'h3, 1, 32'h0, 32'h0));
    apply("rs4", mk(1, 6'h00, 0, 32'h0, 1, 8'h04, 0, 32'h0, 0, 32'h0, 32'h04030201));

    // Asynchronous reset while a word is presented in HOLD
    idle_inputs();
    stall_in = 6'h02;
    #2 rst_in = 1'b1;
    #1;
    check("arst_hold output_instru", output_instru,      32'd0);
    check("arst_hold stall_req",     {31'd0, stall_req}, 32'd0);
    check("arst_hold mem_req",       {31'd0, mem_req},   32'd0);
    #1 rst_in = 1'b0;
    apply("post_hold", mk(1, 6'h00, 0, 32'h0, 0, 8'h00, 1, 32'h0, 1, 32'h0, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
